// File: rtl/keyword_vote_filter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : keyword_vote_filter_if
// Description : Bundles the classifier input handshake, the detection event
//               port and the status counters of keyword_vote_filter.
//               The master side drives frames and accepts events; the slave
//               side is the filter.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
interface keyword_vote_filter_if #(
  parameter int KW_WIDTH = 4
);
  logic                kin_valid;
  logic                kin_ready;
  logic [KW_WIDTH-1:0] kin_keyword;
  logic                det_valid;
  logic                det_ready;
  logic [KW_WIDTH-1:0] det_keyword;
  logic [7:0]          det_count;
  logic [15:0]         frame_count;

  modport master (
    output kin_valid, kin_keyword, det_ready,
    input  kin_ready, det_valid, det_keyword, det_count, frame_count
  );

  modport slave (
    input  kin_valid, kin_keyword, det_ready,
    output kin_ready, det_valid, det_keyword, det_count, frame_count
  );
endinterface
`default_nettype wire

// File: rtl/keyword_vote_filter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : keyword_vote_filter
// Description : Run-length voting on the per-frame keyword stream. An event is
//               raised after THRESHOLD consecutive identical non-silence
//               frames, held on a single-entry valid/ready port, and followed
//               by a holdoff window of HOLDOFF discarded frames.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module keyword_vote_filter #(
  parameter int KW_WIDTH      = 4,
  parameter int THRESHOLD     = 3,
  parameter int HOLDOFF       = 8,
  parameter int SILENCE_CLASS = 0
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  keyword_vote_filter_if.slave kw_bus
);

  localparam int RUN_W  = $clog2(THRESHOLD + 1);
  localparam int HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  localparam logic [RUN_W-1:0]    RUN_MAX   = RUN_W'(THRESHOLD);
  localparam logic [RUN_W-1:0]    RUN_ONE   = RUN_W'(1);
  localparam logic [HOLD_W-1:0]   HOLD_INIT = HOLD_W'(HOLDOFF);
  localparam logic [HOLD_W-1:0]   HOLD_ONE  = HOLD_W'(1);
  localparam logic [KW_WIDTH-1:0] SIL_KW    = KW_WIDTH'(SILENCE_CLASS);

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_EMIT    = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  state_t              state_q,       state_d;
  logic [RUN_W-1:0]    run_cnt_q,     run_cnt_d;
  logic [KW_WIDTH-1:0] last_kw_q,     last_kw_d;
  logic                last_valid_q,  last_valid_d;
  logic [HOLD_W-1:0]   hold_cnt_q,    hold_cnt_d;
  logic                det_valid_q,   det_valid_d;
  logic [KW_WIDTH-1:0] det_kw_q,      det_kw_d;
  logic [7:0]          det_count_q,   det_count_d;
  logic [15:0]         frame_count_q, frame_count_d;

  logic                in_xfer;
  logic                out_xfer;
  logic [RUN_W-1:0]    run_next;

  // Input is only stalled while an event waits for the consumer, which keeps
  // input and output transfers mutually exclusive.
  assign kw_bus.kin_ready   = (state_q != ST_EMIT);
  assign kw_bus.det_valid   = det_valid_q;
  assign kw_bus.det_keyword = det_kw_q;
  assign kw_bus.det_count   = det_count_q;
  assign kw_bus.frame_count = frame_count_q;

  assign in_xfer  = kw_bus.kin_valid & kw_bus.kin_ready;
  assign out_xfer = det_valid_q & kw_bus.det_ready;

  // Next-state logic for the voting FSM, run history, event slot and counters.
  always_comb begin
    state_d       = state_q;
    run_cnt_d     = run_cnt_q;
    last_kw_d     = last_kw_q;
    last_valid_d  = last_valid_q;
    hold_cnt_d    = hold_cnt_q;
    det_valid_d   = det_valid_q;
    det_kw_d      = det_kw_q;
    det_count_d   = det_count_q;
    frame_count_d = frame_count_q;
    run_next      = run_cnt_q;

    if (in_xfer) begin
      frame_count_d = frame_count_q + 16'd1;
    end

    case (state_q)
      ST_ACCUM: begin
        if (in_xfer) begin
          if (last_valid_q && (kw_bus.kin_keyword == last_kw_q)) begin
            // A silence run may sit at the ceiling indefinitely.
            run_next = (run_cnt_q < RUN_MAX) ? run_cnt_q + RUN_ONE : run_cnt_q;
          end else begin
            run_next     = RUN_ONE;
            last_kw_d    = kw_bus.kin_keyword;
            last_valid_d = 1'b1;
          end
          run_cnt_d = run_next;
          if ((run_next == RUN_MAX) && (kw_bus.kin_keyword != SIL_KW)) begin
            det_valid_d = 1'b1;
            det_kw_d    = kw_bus.kin_keyword;
            state_d     = ST_EMIT;
          end
        end
      end

      ST_EMIT: begin
        if (out_xfer) begin
          det_valid_d  = 1'b0;
          det_count_d  = (det_count_q != 8'hFF) ? det_count_q + 8'd1 : det_count_q;
          run_cnt_d    = '0;
          last_valid_d = 1'b0;
          if (HOLD_INIT == '0) begin
            state_d = ST_ACCUM;
          end else begin
            state_d    = ST_HOLDOFF;
            hold_cnt_d = HOLD_INIT;
          end
        end
      end

      ST_HOLDOFF: begin
        if (in_xfer) begin
          hold_cnt_d = hold_cnt_q - HOLD_ONE;
          if (hold_cnt_q == HOLD_ONE) begin
            state_d = ST_ACCUM;
          end
        end
      end

      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  // State register; reset drops any pending event and clears all history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_ACCUM;
      run_cnt_q     <= '0;
      last_kw_q     <= '0;
      last_valid_q  <= 1'b0;
      hold_cnt_q    <= '0;
      det_valid_q   <= 1'b0;
      det_kw_q      <= '0;
      det_count_q   <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      run_cnt_q     <= run_cnt_d;
      last_kw_q     <= last_kw_d;
      last_valid_q  <= last_valid_d;
      hold_cnt_q    <= hold_cnt_d;
      det_valid_q   <= det_valid_d;
      det_kw_q      <= det_kw_d;
      det_count_q   <= det_count_d;
      frame_count_q <= frame_count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keyword_vote_filter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module      : tb_keyword_vote_filter
// Description : Self-checking bench for keyword_vote_filter. A frame-level
//               reference model (keyword history, integer run length, mode,
//               remaining holdoff) predicts every output each cycle.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_keyword_vote_filter;

  localparam int KW   = 4;
  localparam int THR  = 3;
  localparam int HOLD = 8;
  localparam int SIL  = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  keyword_vote_filter_if #(.KW_WIDTH(KW)) bus ();

  keyword_vote_filter #(
    .KW_WIDTH      (KW),
    .THRESHOLD     (THR),
    .HOLDOFF       (HOLD),
    .SILENCE_CLASS (SIL)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .kw_bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: 0 = collecting votes, 1 = event pending, 2 = holdoff.
  int        m_mode;
  int        m_run;
  int        m_hold;
  bit        m_have_last;
  int        m_last_kw;
  bit        m_det_valid;
  int        m_det_kw;
  int        m_det_count;
  int        m_frames;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode      = 0;
    m_run       = 0;
    m_hold      = 0;
    m_have_last = 1'b0;
    m_last_kw   = 0;
    m_det_valid = 1'b0;
    m_det_kw    = 0;
    m_det_count = 0;
    m_frames    = 0;
  endfunction

  // Advance the model by one clock given this cycle's inputs.
  function automatic void model_step(input bit v, input int kw, input bit r);
    bit accept_in;
    accept_in = v && (m_mode != 1);
    if (accept_in) m_frames = (m_frames + 1) % 65536;
    if (m_mode == 0 && accept_in) begin
      if (m_have_last && kw == m_last_kw) m_run = m_run + 1;
      else begin
        m_have_last = 1'b1;
        m_last_kw   = kw;
        m_run       = 1;
      end
      if (m_run == THR && kw != SIL) begin
        m_det_valid = 1'b1;
        m_det_kw    = kw;
        m_mode      = 1;
      end
    end else if (m_mode == 1 && r) begin
      m_det_valid = 1'b0;
      if (m_det_count < 255) m_det_count = m_det_count + 1;
      m_have_last = 1'b0;
      m_run       = 0;
      if (HOLD > 0) begin
        m_mode = 2;
        m_hold = HOLD;
      end else m_mode = 0;
    end else if (m_mode == 2 && accept_in) begin
      m_hold = m_hold - 1;
      if (m_hold == 0) m_mode = 0;
    end
  endfunction

  task automatic check_outputs(input string tag);
    check_eq({tag, ".kin_ready"},   32'(bus.kin_ready),   32'(m_mode != 1));
    check_eq({tag, ".det_valid"},   32'(bus.det_valid),   32'(m_det_valid));
    check_eq({tag, ".det_keyword"}, 32'(bus.det_keyword), 32'(m_det_kw));
    check_eq({tag, ".det_count"},   32'(bus.det_count),   32'(m_det_count));
    check_eq({tag, ".frame_count"}, 32'(bus.frame_count), 32'(m_frames));
  endtask

  // Called at a falling edge: check, drive, let one rising edge pass.
  task automatic cycle(input string tag, input bit v, input int kw, input bit r);
    check_outputs(tag);
    bus.kin_valid   = v;
    bus.kin_keyword = KW'(kw);
    bus.det_ready   = r;
    model_step(v, kw, r);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.kin_valid = 1'b0;
    bus.det_ready = 1'b0;
    #1;
    model_reset();
    check_eq("rst.det_valid",   32'(bus.det_valid),   32'd0);
    check_eq("rst.det_count",   32'(bus.det_count),   32'd0);
    check_eq("rst.frame_count", 32'(bus.frame_count), 32'd0);
    check_eq("rst.det_keyword", 32'(bus.det_keyword), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bus.kin_valid   = 1'b0;
    bus.kin_keyword = '0;
    bus.det_ready   = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Three identical frames fire one cycle after the third transfer.
    for (int i = 0; i < 3; i++) cycle("t1", 1'b1, 5, 1'b1);
    check_eq("t1.fire_valid", 32'(bus.det_valid), 32'd1);
    check_eq("t1.fire_kw",    32'(bus.det_keyword), 32'd5);
    cycle("t1h", 1'b0, 0, 1'b1);
    check_eq("t1.count", 32'(bus.det_count), 32'd1);

    // Interrupted run: no event, then one more 5 completes the run of three.
    do_reset();
    begin
      int seq[5] = '{5, 5, 2, 5, 5};
      foreach (seq[i]) cycle("t2", 1'b1, seq[i], 1'b1);
    end
    check_eq("t2.no_det", 32'(bus.det_valid), 32'd0);
    check_eq("t2.frames", 32'(bus.frame_count), 32'd5);
    cycle("t2b", 1'b1, 5, 1'b0);
    check_eq("t2.third5", 32'(bus.det_valid), 32'd1);

    // Silence never fires.
    do_reset();
    for (int i = 0; i < 6; i++) cycle("t3", 1'b1, SIL, 1'b1);
    check_eq("t3.no_det", 32'(bus.det_valid), 32'd0);
    check_eq("t3.ready",  32'(bus.kin_ready), 32'd1);

    // Back-pressured event stays stable, then handoff and holdoff.
    do_reset();
    for (int i = 0; i < 3; i++) cycle("t4", 1'b1, 9, 1'b0);
    for (int i = 0; i < 10; i++) cycle("t4s", 1'b1, 3, 1'b0);
    cycle("t4r", 1'b1, 3, 1'b1);
    check_eq("t4.handoff", 32'(bus.det_valid), 32'd0);

    // Holdoff: 8 frames of 7 discarded, then 7,7,7 fire.
    for (int i = 0; i < 8; i++) cycle("t5h", 1'b1, 7, 1'b1);
    check_eq("t5.not_early", 32'(bus.det_valid), 32'd0);
    for (int i = 0; i < 2; i++) cycle("t5a", 1'b1, 7, 1'b0);
    check_eq("t5.two_only", 32'(bus.det_valid), 32'd0);
    cycle("t5b", 1'b1, 7, 1'b0);
    check_eq("t5.fire", 32'(bus.det_valid), 32'd1);
    check_eq("t5.kw",   32'(bus.det_keyword), 32'd7);

    // Reset while an event is pending, then a normal detection of 4.
    do_reset();
    check_eq("t6.ready", 32'(bus.kin_ready), 32'd1);
    for (int i = 0; i < 3; i++) cycle("t6", 1'b1, 4, 1'b0);
    check_eq("t6.fire", 32'(bus.det_valid), 32'd1);
    check_eq("t6.kw",   32'(bus.det_keyword), 32'd4);

    // Saturation of det_count at 255.
    do_reset();
    for (int n = 0; n < 258; n++) begin
      for (int i = 0; i < 3; i++) cycle("sat", 1'b1, 1 + (n % 15), 1'b0);
      cycle("sat_h", 1'b0, 0, 1'b1);
      for (int i = 0; i < HOLD; i++) cycle("sat_o", 1'b1, 0, 1'b0);
    end
    check_eq("sat.count", 32'(bus.det_count), 32'd255);

    // Randomized traffic from a small keyword alphabet to form runs.
    for (int i = 0; i < 4000; i++) begin
      int pick;
      int kw;
      pick = int'($urandom_range(0, 9));
      kw   = (pick < 2) ? SIL : (pick < 7) ? 5 : (pick < 9) ? 7 : int'($urandom_range(1, 15));
      if (i == 2000) do_reset();
      cycle("rnd", ($urandom_range(0, 4) != 0), kw, ($urandom_range(0, 2) != 0));
    end
    check_outputs("end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
